// File: rtl/router_pkt_src.sv
// Packet source for the router: buffers a host payload, then emits header,
// payload and an XOR parity byte under router backpressure (busy).
module router_pkt_src (
  input  logic       clock,
  input  logic       resetn,
  input  logic       start,
  input  logic [1:0] dest_addr,
  input  logic [5:0] payload_len,
  input  logic [7:0] pl_data,
  input  logic       pl_valid,
  output logic       pl_ready,
  input  logic       busy,
  output logic [7:0] data_out,
  output logic       pkt_valid,
  output logic       tx_active,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    HEADER  = 3'd2,
    PAYLOAD = 3'd3,
    PARITY  = 3'd4
  } state_t;

  state_t     state, state_n;
  logic [1:0] addr_q, addr_n;
  logic [5:0] len_q, len_n;
  logic [5:0] cnt_q, cnt_n;
  logic [7:0] parity_q, parity_n;
  logic [7:0] data_out_n;
  logic       pkt_valid_n, done_n, err_n;
  logic       beat;

  logic [7:0] buffer [0:62];

  assign pl_ready  = (state == COLLECT);
  assign tx_active = (state != IDLE);
  assign beat      = pl_ready && pl_valid;

  // NOTE: the payload buffer has no reset; every byte read back was written
  // earlier in the same packet, so clearing it would only cost logic.
  always_ff @(posedge clock) begin
    if (beat) buffer[cnt_q] <= pl_data;
  end

  // NOTE: every variable gets a hold/default value before the case so no
  // path leaves one unassigned, which would infer a latch.
  always_comb begin
    state_n     = state;
    addr_n      = addr_q;
    len_n       = len_q;
    cnt_n       = cnt_q;
    parity_n    = parity_q;
    data_out_n  = data_out;
    pkt_valid_n = pkt_valid;
    done_n      = 1'b0;
    err_n       = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          if (dest_addr == 2'd3 || payload_len == 6'd0) begin
            err_n = 1'b1;
          end else begin
            addr_n   = dest_addr;
            len_n    = payload_len;
            cnt_n    = 6'd0;
            parity_n = 8'h00;
            state_n  = COLLECT;
          end
        end
      end
      COLLECT: begin
        if (beat) begin
          cnt_n    = cnt_q + 6'd1;
          parity_n = parity_q ^ pl_data;
          if (cnt_q + 6'd1 == len_q) begin
            // Header goes out on the same edge that takes the last beat.
            state_n     = HEADER;
            data_out_n  = {len_q, addr_q};
            pkt_valid_n = 1'b1;
            parity_n    = parity_q ^ pl_data ^ {len_q, addr_q};
            cnt_n       = 6'd0;
          end
        end
      end
      HEADER: begin
        if (!busy) begin
          data_out_n = buffer[0];
          cnt_n      = 6'd1;
          state_n    = PAYLOAD;
        end
      end
      PAYLOAD: begin
        // cnt_q is the index of the next payload byte to load.
        if (!busy) begin
          if (cnt_q == len_q) begin
            data_out_n  = parity_q;
            pkt_valid_n = 1'b0;
            state_n     = PARITY;
          end else begin
            data_out_n = buffer[cnt_q];
            cnt_n      = cnt_q + 6'd1;
          end
        end
      end
      PARITY: begin
        if (!busy) begin
          done_n     = 1'b1;
          data_out_n = 8'h00;
          state_n    = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values computed above.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state     <= IDLE;
      addr_q    <= 2'd0;
      len_q     <= 6'd0;
      cnt_q     <= 6'd0;
      parity_q  <= 8'h00;
      data_out  <= 8'h00;
      pkt_valid <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      addr_q    <= addr_n;
      len_q     <= len_n;
      cnt_q     <= cnt_n;
      parity_q  <= parity_n;
      data_out  <= data_out_n;
      pkt_valid <= pkt_valid_n;
      done      <= done_n;
      err       <= err_n;
    end
  end

endmodule

// File: tb/tb_router_pkt_src.sv
// Self-checking bench for router_pkt_src: expected byte stream is built from
// the packet rules (header, payload, XOR parity) and compared per cycle.
module tb_router_pkt_src;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic [1:0] dest_addr = 2'd0;
  logic [5:0] payload_len = 6'd0;
  logic [7:0] pl_data = 8'h00;
  logic       pl_valid = 1'b0;
  logic       busy = 1'b0;
  logic       pl_ready;
  logic [7:0] data_out;
  logic       pkt_valid;
  logic       tx_active;
  logic       done;
  logic       err;

  int checks = 0;
  int errors = 0;
  logic [7:0] tx_bytes [$];

  router_pkt_src dut (
    .clock       (clock),
    .resetn      (resetn),
    .start       (start),
    .dest_addr   (dest_addr),
    .payload_len (payload_len),
    .pl_data     (pl_data),
    .pl_valid    (pl_valid),
    .pl_ready    (pl_ready),
    .busy        (busy),
    .data_out    (data_out),
    .pkt_valid   (pkt_valid),
    .tx_active   (tx_active),
    .done        (done),
    .err         (err)
  );

  always #5 clock = ~clock;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_data_out"}, data_out, 8'h00);
    check({tag, "_pkt_valid"}, pkt_valid, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_err"}, err, 1'b0);
    check({tag, "_tx_active"}, tx_active, 1'b0);
    check({tag, "_pl_ready"}, pl_ready, 1'b0);
  endtask

  task automatic fill_random(input int len);
    tx_bytes.delete();
    for (int i = 0; i < len; i++) tx_bytes.push_back(8'($urandom));
  endtask

  // Sends tx_bytes to addr. Entered and left at a negedge.
  // vmode: 0 valid always, 1 valid toggling, 2 random. bmode: 0 no busy, 1 random busy.
  // poke_at: stream index at which an invalid start is pulsed (-1 none).
  // abort_at: stream index at which reset is applied (-1 none).
  task automatic send_packet(input logic [1:0] addr, input int vmode, input int bmode,
                             input int hdr_stall, input int poke_at, input int abort_at);
    logic [7:0] exp_q [$];
    logic [7:0] par;
    logic [7:0] hdr;
    int len, sent, budget, idx, stalls;
    logic v, b, tog;
    len = tx_bytes.size();
    hdr = {len[5:0], addr};
    exp_q.push_back(hdr);
    par = hdr;
    foreach (tx_bytes[i]) begin
      exp_q.push_back(tx_bytes[i]);
      par = par ^ tx_bytes[i];
    end
    exp_q.push_back(par);

    start = 1'b1; dest_addr = addr; payload_len = len[5:0];
    @(negedge clock);
    start = 1'b0;
    check("collect_ready", pl_ready, 1'b1);

    sent = 0; budget = 0; tog = 1'b1;
    while (sent < len && budget < 2000) begin
      case (vmode)
        0:       v = 1'b1;
        1:       begin v = tog; tog = ~tog; end
        default: v = 1'($urandom_range(0, 1));
      endcase
      busy     = 1'($urandom_range(0, 1));
      pl_valid = v;
      pl_data  = v ? tx_bytes[sent] : 8'($urandom);
      if (v && pl_ready) sent++;
      @(negedge clock);
      budget++;
    end
    pl_valid = 1'b0;
    check("collect_count", sent, len);

    budget = 0;
    while (pkt_valid !== 1'b1 && budget < 8) begin
      busy = 1'b1;
      @(negedge clock);
      budget++;
    end
    check("header_seen", pkt_valid, 1'b1);

    idx = 0; stalls = 0; budget = 0;
    while (idx < len + 2 && budget < 4000) begin
      if (idx == abort_at) begin
        resetn = 1'b0; busy = 1'b0;
        @(negedge clock);
        check_idle_outputs("abort");
        resetn = 1'b1;
        return;
      end
      check($sformatf("byte%0d", idx), data_out, exp_q[idx]);
      check($sformatf("pkt_valid%0d", idx), pkt_valid, (idx <= len));
      check("stream_pl_ready", pl_ready, 1'b0);
      check("stream_tx_active", tx_active, 1'b1);
      check("stream_done", done, 1'b0);
      check("stream_err", err, 1'b0);
      if (idx == 0 && stalls < hdr_stall) begin
        b = 1'b1; stalls++;
      end else if (bmode != 0) begin
        b = 1'($urandom_range(0, 1));
      end else begin
        b = 1'b0;
      end
      busy = b;
      if (idx == poke_at) begin
        start = 1'b1; dest_addr = 2'd3; payload_len = 6'd5;
      end else begin
        start = 1'b0;
      end
      @(negedge clock);
      budget++;
      if (!b) idx++;
    end
    busy = 1'b0; start = 1'b0;
    check("stream_length", idx, len + 2);
    check("done_pulse", done, 1'b1);
    check("done_data_out", data_out, 8'h00);
    check("done_tx_active", tx_active, 1'b0);
    check("done_pkt_valid", pkt_valid, 1'b0);
  endtask

  task automatic reject(input logic [1:0] addr, input logic [5:0] len);
    start = 1'b1; dest_addr = addr; payload_len = len;
    @(negedge clock);
    start = 1'b0;
    check("reject_err", err, 1'b1);
    check("reject_pl_ready", pl_ready, 1'b0);
    check("reject_pkt_valid", pkt_valid, 1'b0);
    check("reject_tx_active", tx_active, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("reject_after_err", err, 1'b0);
      check("reject_after_pl_ready", pl_ready, 1'b0);
      check("reject_after_pkt_valid", pkt_valid, 1'b0);
    end
  endtask

  initial begin
    resetn = 1'b0;
    repeat (3) @(negedge clock);
    check_idle_outputs("reset");
    resetn = 1'b1;
    @(negedge clock);

    // Reference packet: addr 1, A5 3C 0F, no stalls.
    tx_bytes = {8'hA5, 8'h3C, 8'h0F};
    send_packet(2'd1, 0, 0, 0, -1, -1);
    @(negedge clock);
    check("done_one_cycle", done, 1'b0);

    // Same packet with the header stalled for three cycles.
    tx_bytes = {8'hA5, 8'h3C, 8'h0F};
    send_packet(2'd1, 0, 0, 3, -1, -1);
    @(negedge clock);

    reject(2'd3, 6'd5);
    reject(2'd1, 6'd0);

    // Maximum length, toggling pl_valid, random busy.
    fill_random(63);
    send_packet(2'd2, 1, 1, 0, -1, -1);
    @(negedge clock);

    // Reset during payload byte 2 of 5, then a clean packet.
    fill_random(5);
    send_packet(2'd0, 0, 0, 0, -1, 2);
    repeat (3) begin
      @(negedge clock);
      check("post_abort_done", done, 1'b0);
      check("post_abort_tx_active", tx_active, 1'b0);
    end
    fill_random(5);
    send_packet(2'd0, 2, 1, 0, -1, -1);
    @(negedge clock);

    // Start pulsed mid-payload must be ignored.
    fill_random(4);
    send_packet(2'd1, 2, 1, 0, 2, -1);
    @(negedge clock);
    check("poke_no_err", err, 1'b0);

    // Back-to-back packets, first one of length 1.
    for (int p = 0; p < 6; p++) begin
      fill_random(p == 0 ? 1 : int'($urandom_range(1, 20)));
      send_packet(2'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                  int'($urandom_range(0, 1)), int'($urandom_range(0, 2)), -1, -1);
    end
    @(negedge clock);
    check("final_done_low", done, 1'b0);
    check("final_idle", tx_active, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/router_pkt_src.md
ROUTER_PKT_SRC -- requirements
Module: router_pkt_src

Interface
REQ-001 clock  input  1  rising-edge clock; all state and outputs update on it.
REQ-002 resetn  input  1  reset, synchronous, active-low.
REQ-003 start  input  1  one-cycle request to send one packet; sampled only in IDLE.
REQ-004 dest_addr  input  2  destination port 0..2; sampled with start.
REQ-005 payload_len  input  6  payload byte count 1..63; sampled with start.
REQ-006 pl_data  input  8  payload byte from host.
REQ-007 pl_valid  input  1  pl_data valid.
REQ-008 pl_ready  output  1  block accepts pl_data; a beat transfers when pl_valid && pl_ready at an edge.
REQ-009 busy  input  1  router stall; when 1, the byte on data_out is not consumed.
REQ-010 data_out  output  8  byte to router (header, payload, parity).
REQ-011 pkt_valid  output  1  high for header and payload bytes, low for parity.
REQ-012 tx_active  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse when the parity byte is consumed.
REQ-014 err  output  1  one-cycle pulse when start is rejected.

Function
REQ-015 States SHALL be IDLE, COLLECT, HEADER, PAYLOAD, PARITY; all outputs SHALL be registered except pl_ready and tx_active, which SHALL be decoded from state.
REQ-016 IDLE, start=1, dest_addr=3 or payload_len=0: err=1 next cycle, state stays IDLE, nothing latched.
REQ-017 IDLE, start=1, valid request: latch addr/len, byte counter=0, parity=0, go COLLECT; start outside IDLE SHALL be ignored.
REQ-018 COLLECT: pl_ready=1; each transferred beat written to a 63x8 buffer at counter, counter+1, parity ^= byte; busy ignored.
REQ-019 COLLECT, beat making counter==len: next edge enters HEADER with data_out={len,addr}, pkt_valid=1, parity ^= header, counter=0.
REQ-020 HEADER/PAYLOAD: at an edge with busy=1, data_out and pkt_valid SHALL hold unchanged.
REQ-021 HEADER, busy=0: load buffer[0] to data_out, go PAYLOAD, pkt_valid stays 1.
REQ-022 PAYLOAD, busy=0, byte index < len-1: load next buffer byte; pkt_valid SHALL stay 1 continuously (no gaps) until the last payload byte is consumed.
REQ-023 PAYLOAD, busy=0, last byte: data_out=parity (XOR of header and all payload bytes), pkt_valid=0, go PARITY.
REQ-024 PARITY: hold parity while busy=1; at edge with busy=0: done=1 for one cycle, data_out=8'h00, go IDLE.
REQ-025 pl_ready SHALL be 0 in every state except COLLECT.
REQ-026 A new start SHALL be accepted in the cycle after done (back-to-back packets).
REQ-027 Counter width 6 bits; no wrap possible since len <= 63.

Reset
REQ-028 resetn=0 at an edge: state=IDLE, data_out=8'h00, pkt_valid=0, done=0, err=0, counter=0, parity=0; buffer contents undefined.
REQ-029 Reset SHALL override all inputs, including mid-COLLECT or mid-PAYLOAD; the partial packet is discarded and no done is issued.

Verification
REQ-030 addr=1, len=3, payload A5,3C,0F, busy=0 -> data_out 0x0D,A5,3C,0F with pkt_valid=1, then 0x9B with pkt_valid=0, then done=1 for one cycle.
REQ-031 Same packet, busy=1 for 3 cycles in HEADER -> data_out=0x0D, pkt_valid=1 held 4 cycles, then normal sequence.
REQ-032 start with dest_addr=3, len=5 -> err=1 one cycle, pl_ready stays 0, pkt_valid never 1.
REQ-033 addr=2, len=63, pl_valid toggling every cycle -> 63 buffered beats, header 0xFE, pkt_valid high for 64 consecutive consumed bytes, correct parity.
REQ-034 resetn=0 at payload byte 2 of 5 -> next cycle all outputs 0, state IDLE; following start sends a full packet correctly.
REQ-035 start pulsed during PAYLOAD -> ignored; err=0; current packet completes unchanged.
